rxe_crc_check: RTL
==================

# rxe_crc_check

Receive-path filter stage between the preamble/nibble assembler and the byte-to-word memory writer. Checks the IEEE 802.3 CRC-32 (FCS) of each received frame and strips the four trailing FCS bytes so the writer stores payload only. Flags a bad CRC, or a frame too short to carry an FCS, at end of frame. The output stream keeps the same contiguous byte-per-cycle `v/d` convention the writer consumes.

## Interface
- No parameters.
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_en  in  1  1 = check and strip FCS; 0 = bypass (no stripping, no check); sampled only on the first byte of a frame
- i_v  in  1  byte valid; a frame is one contiguous run of i_v high, one byte per cycle
- i_d  in  8  received byte
- o_v  out  1  payload byte valid (contiguous run per frame)
- o_d  out  8  payload byte
- o_err  out  1  CRC/short-frame error for the frame just ended; held until the next frame starts

## Operation
- CRC: reflected polynomial 0xEDB88320, LSB-first, init 0xFFFFFFFF, updated over every input byte, FCS included. A good frame leaves the register at residue 0xDEBB20E3. No final inversion.
- 4-byte delay line (b0 newest … b3 oldest) plus a fill counter fcnt (0..4, saturating).
- States:
  - IDLE: i_v=0 and o_v=0.
  - FILL: fcnt<4, no output.
  - PASS: fcnt==4, each new byte pushes b3 to the output.
- IDLE→FILL on i_v rising:
  - latch i_en into mode
  - CRC loaded with init, updated with the first byte in the same cycle
  - fcnt=1
  - o_err cleared
- FILL→PASS when the fourth byte is accepted.
- PASS: on each i_v=1 cycle, o_v<=1 and o_d<=b3; shift.
- End of frame (first cycle with i_v=0 after a run):
  - o_v<=0
  - o_err<=1 if mode=1 and (fcnt<4 or crc≠0xDEBB20E3)
  - delay line, fcnt and CRC cleared
  - return to IDLE
- The four buffered bytes (the FCS) are never output.
- Frames of 1–4 bytes: no o_v at all; o_err=1 (4-byte frame with a correct CRC of the empty payload gives o_err=0).
- Bypass (mode=0): o_v<=i_v and o_d<=i_d each cycle (1-cycle register). No stripping. o_err stays 0.
- Back-to-back frames need at least one i_v=0 cycle between them. That gap is the end-of-frame event.

## Timing
- Reset values: o_v=0, o_d=0, o_err=0, fcnt=0, CRC=0xFFFFFFFF, delay line 0, mode=0.
- Latency (check mode): input byte k (0-based) appears on o_d the cycle after input byte k+4 is accepted.
- Output count per frame: N−4 bytes for N≥4; 0 for N<4.
- o_v falls on the same edge that samples i_v=0. That is the cycle after the last FCS byte, so the writer sees o_v drop exactly at frame end.
- o_err is valid from the edge where o_v falls and is stable until the first byte of the next frame is accepted.
- Bypass latency: 1 cycle.
- i_en changes mid-frame are ignored.
- Reset mid-frame: all state returns to reset values on the next edge. Output stops immediately. Remaining i_v-high cycles are treated as a new frame starting at the first i_v=1 after reset is released; the driver keeps i_v low for ≥1 cycle after reset.

## Structure
- Shared package rxe_pkg:
  - CRC32_POLY=32'hEDB88320
  - CRC32_INIT=32'hFFFFFFFF
  - CRC32_RESIDUE=32'hDEBB20E3
  - FCS_BYTES=4
- One sub-module, rxe_crc32_byte: combinational 8-step bit-serial update, crc_in[31:0] + byte[7:0] → crc_out[31:0]. Reused by the transmit-side FCS generator.
- Top level holds the delay line, fcnt, mode, CRC register and error flag.

## Test plan
- Good frame: i_en=1, bytes 31 32 33 34 35 36 37 38 39 26 39 F4 CB contiguous. Required: o_d = 31…39 (9 bytes, first one the cycle after byte 0x35 is accepted), o_v low after byte 0x39, o_err=0.
- Corrupt FCS: same frame with last byte CA. Required: identical 9 output bytes, then o_err=1 from o_v fall until the next frame start.
- Short frame: i_en=1, bytes AA BB C0. Required: o_v never asserts; o_err=1 one cycle after i_v falls.
- Bypass: i_en=0, same 13-byte good frame. Required: all 13 bytes out with 1-cycle latency; o_err=0. Repeat with last byte CA: still o_err=0.
- Back-to-back: good frame, one idle cycle, corrupt frame, one idle cycle, good frame. Required: o_err sequence 0, 1, 0, with each value cleared on the next frame's first byte; 9 output bytes per frame.
- Reset mid-frame: assert i_reset after the 7th byte of the good frame. Required: o_v=0, o_err=0 next edge. A following clean good frame passes with o_err=0.

Source files
------------

// File: rtl/rxe_pkg.sv
// Shared receive-path constants and types.
// CRC-32 (802.3) parameters, FCS length, filter state encoding.
package rxe_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          FCS_BYTES     = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_PASS,
    S_BYP
  } rxe_state_e;

endpackage

// File: rtl/rxe_crc32_byte.sv
// Combinational CRC-32 byte update, reflected, LSB first.
// Ports: crc_i (current reg), byte_i (data), crc_o (updated reg).
module rxe_crc32_byte
  import rxe_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, byte_i};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC32_POLY;
      else      c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/rxe_crc_check.sv
// Receive FCS checker: strips 4 trailing FCS bytes, flags bad CRC.
// Ports: i_clk, i_reset, i_en, i_v/i_d in; o_v/o_d out, o_err.
module rxe_crc_check
  import rxe_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_err
);

  localparam logic [2:0] FCS_CNT = 3'(FCS_BYTES);

  rxe_state_e  state_q, state_d;
  logic        mode_q, mode_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] dl_q, dl_d;
  logic        ov_q, ov_d;
  logic [7:0]  od_q, od_d;
  logic        err_q, err_d;

  logic [31:0] crc_in;
  logic [31:0] crc_upd;

  // A new frame always starts from the init value.
  assign crc_in = (state_q == S_IDLE) ? CRC32_INIT : crc_q;

  rxe_crc32_byte u_crc (
    .crc_i  (crc_in),
    .byte_i (i_d),
    .crc_o  (crc_upd)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      fcnt_q  <= 3'd0;
      crc_q   <= CRC32_INIT;
      dl_q    <= 32'h0;
      ov_q    <= 1'b0;
      od_q    <= 8'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fcnt_q  <= fcnt_d;
      crc_q   <= crc_d;
      dl_q    <= dl_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      err_q   <= err_d;
    end
  end

  // dl[7:0] is the newest byte, dl[31:24] the oldest.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fcnt_d  = fcnt_q;
    crc_d   = crc_q;
    dl_d    = dl_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_v) begin
          mode_d = i_en;
          crc_d  = crc_upd;
          err_d  = 1'b0;
          if (i_en) begin
            state_d = S_FILL;
            fcnt_d  = 3'd1;
            dl_d    = {dl_q[23:0], i_d};
          end else begin
            state_d = S_BYP;
            ov_d    = 1'b1;
            od_d    = i_d;
          end
        end
      end
      S_FILL, S_PASS: begin
        if (i_v) begin
          crc_d = crc_upd;
          dl_d  = {dl_q[23:0], i_d};
          if (state_q == S_PASS) begin
            ov_d = 1'b1;
            od_d = dl_q[31:24];
          end else begin
            fcnt_d = fcnt_q + 3'd1;
            if (fcnt_q == FCS_CNT - 3'd1) state_d = S_PASS;
          end
        end else begin
          err_d   = mode_q & ((fcnt_q < FCS_CNT) |
                              (crc_q != CRC32_RESIDUE));
          state_d = S_IDLE;
          fcnt_d  = 3'd0;
          crc_d   = CRC32_INIT;
          dl_d    = 32'h0;
        end
      end
      S_BYP: begin
        if (i_v) begin
          crc_d = crc_upd;
          ov_d  = 1'b1;
          od_d  = i_d;
        end else begin
          state_d = S_IDLE;
          crc_d   = CRC32_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_v   = ov_q;
  assign o_d   = od_q;
  assign o_err = err_q;

endmodule
